// File: rtl/usb_tx_packet_engine.sv
// Full-speed USB packet serialiser: SYNC, payload, optional CRC16, EOP with NRZI encoding and bit stuffing.
// Define USB_TX_CRC16_EN to append the CRC16 field; the default build sends no CRC.
module usb_tx_packet_engine #(
  parameter int DATA_BYTES   = 8,
  parameter int CLKS_PER_BIT = 8,
  parameter int LEN_W        = $clog2(DATA_BYTES + 1)
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic                    tx_start,
  input  logic [LEN_W-1:0]        tx_len,
  input  logic [DATA_BYTES*8-1:0] tx_data,
  output logic                    d_plus,
  output logic                    d_minus,
  output logic                    tx_busy,
  output logic                    tx_done
);

  localparam int               TIM_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [TIM_W-1:0] TIM_LAST = TIM_W'(CLKS_PER_BIT - 1);
  localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(DATA_BYTES);

  typedef enum logic [2:0] {
    IDLE,
    SYNC,
    DATA,
`ifdef USB_TX_CRC16_EN
    CRC,
`endif
    EOP_SE0,
    EOP_J
  } state_t;

  state_t                  state;
  logic [TIM_W-1:0]        timer;
  logic [2:0]              bit_idx;
  logic [LEN_W-1:0]        byte_idx;
  logic [LEN_W-1:0]        len_q;
  logic [DATA_BYTES*8-1:0] sh_q;
  logic [2:0]              ones_q;
  logic                    last_bit;
`ifdef USB_TX_CRC16_EN
  logic [15:0]             crc_q;
  logic [3:0]              crc_idx;
`endif

  function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len);
    return (len > LEN_MAX) ? LEN_MAX : len;
  endfunction

  // A 0 toggles the line, a 1 holds it; lvl is the current D+ level (J = 1).
  function automatic logic [1:0] nrzi(input logic lvl, input logic b);
    logic nl;
    nl = b ? lvl : ~lvl;
    return {nl, ~nl};
  endfunction

  function automatic logic [2:0] ones_next(input logic [2:0] ones, input logic b);
    return b ? (ones + 3'd1) : 3'd0;
  endfunction

`ifdef USB_TX_CRC16_EN
  function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic b);
    return (crc[0] ^ b) ? ((crc >> 1) ^ 16'hA001) : (crc >> 1);
  endfunction
`endif

  // The bit on the line is the final one before the CRC/EOP tail.
  always_comb begin
    last_bit = 1'b0;
    if (bit_idx == 3'd7) begin
      if (state == SYNC)
        last_bit = (len_q == '0);
      else if (state == DATA)
        last_bit = (byte_idx == (len_q - LEN_W'(1)));
    end
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state    <= IDLE;
      timer    <= '0;
      bit_idx  <= '0;
      byte_idx <= '0;
      len_q    <= '0;
      sh_q     <= '0;
      ones_q   <= '0;
      d_plus   <= 1'b1;
      d_minus  <= 1'b0;
      tx_busy  <= 1'b0;
      tx_done  <= 1'b0;
`ifdef USB_TX_CRC16_EN
      crc_q    <= '0;
      crc_idx  <= '0;
`endif
    end else begin
      tx_done <= 1'b0;
      if (state == IDLE) begin
        if (tx_start) begin
          state    <= SYNC;
          timer    <= '0;
          bit_idx  <= '0;
          byte_idx <= '0;
          len_q    <= clamp_len(tx_len);
          sh_q     <= tx_data;
          ones_q   <= '0;
          tx_busy  <= 1'b1;
          d_plus   <= 1'b0;
          d_minus  <= 1'b1;
`ifdef USB_TX_CRC16_EN
          crc_q    <= 16'hFFFF;
          crc_idx  <= '0;
`endif
        end
      end else if (timer != TIM_LAST) begin
        timer <= timer + TIM_W'(1);
      end else begin
        timer <= '0;
        case (state)
          EOP_SE0: begin
            if (bit_idx == 3'd0) begin
              bit_idx <= 3'd1;
            end else begin
              state   <= EOP_J;
              d_plus  <= 1'b1;
              d_minus <= 1'b0;
            end
          end
          EOP_J: begin
            state   <= IDLE;
            tx_busy <= 1'b0;
            tx_done <= 1'b1;
          end
          default: begin
            if (ones_q == 3'd6) begin
              // Stuffed zero: line toggles, no bit/byte index moves.
              {d_plus, d_minus} <= nrzi(d_plus, 1'b0);
              ones_q            <= '0;
            end else if (last_bit) begin
`ifdef USB_TX_CRC16_EN
              state             <= CRC;
              crc_idx           <= '0;
              crc_q             <= (~crc_q) >> 1;
              {d_plus, d_minus} <= nrzi(d_plus, ~crc_q[0]);
              ones_q            <= ones_next(ones_q, ~crc_q[0]);
`else
              state   <= EOP_SE0;
              bit_idx <= '0;
              ones_q  <= '0;
              d_plus  <= 1'b0;
              d_minus <= 1'b0;
`endif
            end else begin
              case (state)
                SYNC: begin
                  if (bit_idx != 3'd7) begin
                    bit_idx           <= bit_idx + 3'd1;
                    {d_plus, d_minus} <= nrzi(d_plus, bit_idx == 3'd6);
                    ones_q            <= ones_next(ones_q, bit_idx == 3'd6);
                  end else begin
                    state             <= DATA;
                    bit_idx           <= '0;
                    byte_idx          <= '0;
                    {d_plus, d_minus} <= nrzi(d_plus, sh_q[0]);
                    ones_q            <= ones_next(ones_q, sh_q[0]);
`ifdef USB_TX_CRC16_EN
                    crc_q             <= crc16_step(crc_q, sh_q[0]);
`endif
                  end
                end
                DATA: begin
                  bit_idx           <= bit_idx + 3'd1;
                  sh_q              <= sh_q >> 1;
                  {d_plus, d_minus} <= nrzi(d_plus, sh_q[1]);
                  ones_q            <= ones_next(ones_q, sh_q[1]);
                  if (bit_idx == 3'd7)
                    byte_idx <= byte_idx + LEN_W'(1);
`ifdef USB_TX_CRC16_EN
                  crc_q             <= crc16_step(crc_q, sh_q[1]);
`endif
                end
`ifdef USB_TX_CRC16_EN
                CRC: begin
                  if (crc_idx == 4'd15) begin
                    state   <= EOP_SE0;
                    bit_idx <= '0;
                    ones_q  <= '0;
                    d_plus  <= 1'b0;
                    d_minus <= 1'b0;
                  end else begin
                    crc_idx           <= crc_idx + 4'd1;
                    crc_q             <= crc_q >> 1;
                    {d_plus, d_minus} <= nrzi(d_plus, crc_q[0]);
                    ones_q            <= ones_next(ones_q, crc_q[0]);
                  end
                end
`endif
                default: ;
              endcase
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_usb_tx_packet_engine.sv
// Randomised self-checking bench for usb_tx_packet_engine against a bit-list line model.
module tb_usb_tx_packet_engine;

  localparam int DB  = 8;
  localparam int CPB = 8;
  localparam int LW  = $clog2(DB + 1);

  logic          tb_clk = 1'b0;
  logic          n_rst = 1'b0;
  logic          tx_start = 1'b0;
  logic [LW-1:0] tx_len = '0;
  logic [63:0]   tx_data = '0;
  logic          d_plus, d_minus, tx_busy, tx_done;

  int   checks = 0;
  int   errors = 0;
  logic [3:0] exp_q[$];
  logic cur_busy = 1'b0;
  bit   chk_en = 1'b0;

  always #5 tb_clk = ~tb_clk;

  usb_tx_packet_engine #(.DATA_BYTES(DB), .CLKS_PER_BIT(CPB)) dut (
    .clk(tb_clk), .n_rst(n_rst), .tx_start(tx_start), .tx_len(tx_len), .tx_data(tx_data),
    .d_plus(d_plus), .d_minus(d_minus), .tx_busy(tx_busy), .tx_done(tx_done)
  );

`ifdef USB_TX_CRC16_EN
  function automatic logic [15:0] crc_bit(input logic [15:0] c, input bit b);
    return (c[0] ^ b) ? ((c >> 1) ^ 16'hA001) : (c >> 1);
  endfunction
`endif

  // One character per bit time: J, K or 0 (SE0).
  function automatic string build_lines(input logic [63:0] d, input int len);
    bit bits[$];
    bit stf[$];
    int l, ones;
    bit lvl;
    string s, c;
`ifdef USB_TX_CRC16_EN
    logic [15:0] crc;
`endif
    l = (len > DB) ? DB : len;
    for (int i = 0; i < 8; i++) bits.push_back(i == 7);
    for (int i = 0; i < l * 8; i++) bits.push_back(d[i]);
`ifdef USB_TX_CRC16_EN
    crc = 16'hFFFF;
    for (int i = 0; i < l * 8; i++) crc = crc_bit(crc, d[i]);
    for (int i = 0; i < 16; i++) bits.push_back(~crc[i]);
`endif
    ones = 0;
    foreach (bits[i]) begin
      stf.push_back(bits[i]);
      ones = bits[i] ? ones + 1 : 0;
      if (ones == 6) begin stf.push_back(1'b0); ones = 0; end
    end
    lvl = 1'b1;
    s = "";
    foreach (stf[i]) begin
      if (!stf[i]) lvl = ~lvl;
      c = lvl ? "J" : "K";
      s = {s, c};
    end
    return {s, "00J"};
  endfunction

  function automatic int busy_of(input logic [63:0] d, input int len);
    string s;
    s = build_lines(d, len);
    return CPB * s.len();
  endfunction

  task automatic chk_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_str(input string name, input string act, input string exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %s, expected %s", name, act, exp);
    end
  endtask

  // Model: on an accepted start, queue the expected {d_plus,d_minus,busy,done} of every cycle.
  always @(posedge tb_clk) begin
    string s;
    byte   ch;
    logic [1:0] ln;
    if (!n_rst) begin
      exp_q.delete();
      cur_busy = 1'b0;
    end else if (tx_start && !cur_busy) begin
      s = build_lines(tx_data, int'(tx_len));
      for (int i = 0; i < s.len(); i++) begin
        ch = s[i];
        ln = (ch == "J") ? 2'b10 : (ch == "K") ? 2'b01 : 2'b00;
        for (int k = 0; k < CPB; k++) exp_q.push_back({ln, 2'b10});
      end
      exp_q.push_back(4'b1001);
    end
  end

  always @(negedge tb_clk) begin
    logic [3:0] e;
    if (chk_en) begin
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 4'b1000;
      cur_busy = e[1];
      checks++;
      if ({d_plus, d_minus, tx_busy, tx_done} !== e) begin
        errors++;
        $display("FAIL cycle t=%0t dp/dm/busy/done got %b expected %b", $time,
                 {d_plus, d_minus, tx_busy, tx_done}, e);
      end
    end
  end

  // Called at a negedge with the DUT idle.
  task automatic run_packet(input string name, input logic [63:0] d, input int len,
                            input int exp_busy, input bit poke);
    int nb, nd, extra;
    nb = 0; nd = 0; extra = 0;
    tx_data = d; tx_len = LW'(len); tx_start = 1'b1;
    @(negedge tb_clk);
    tx_start = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (tx_busy) nb++;
      if (tx_done) nd++;
      if (nb > 0 && !tx_busy) break;
      tx_start = poke && (i == exp_busy / 2);
      @(negedge tb_clk);
    end
    tx_start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge tb_clk);
      if (tx_done) nd++;
      if (tx_busy) extra++;
    end
    chk_int({name, "_busy_clks"}, nb, exp_busy);
    chk_int({name, "_done_pulses"}, nd, 1);
    chk_int({name, "_no_restart"}, extra, 0);
  endtask

  initial begin
    string s;
    int    n, len, bad;
    logic [63:0] d;
`ifdef USB_TX_CRC16_EN
    logic [15:0] c;
    c = 16'hFFFF;
    for (int i = 0; i < 16; i++) c = crc_bit(c, i == 8);
    for (int i = 0; i < 16; i++) c = crc_bit(c, ~c[0] ^ 1'b0 ? 1'b1 : 1'b1) ;
`endif

    // Model pins against hand-derived line patterns.
`ifdef USB_TX_CRC16_EN
    chk_str("pin_len0_crc", build_lines(64'h0, 0), "KJKJKJKKJKJKJKJKJKJKJKJK00J");
`else
    chk_str("pin_a5", build_lines(64'hA5, 1), "KJKJKJKKKJJKJJKK00J");
    chk_str("pin_ff", build_lines(64'hFF, 1), "KJKJKJKKKKKKKJJJJ00J");
    chk_int("pin_a5_busy", busy_of(64'hA5, 1), 152);
    chk_int("pin_ff_busy", busy_of(64'hFF, 1), 160);
    chk_int("pin_88_busy", busy_of(64'h8888_8888_8888_8888, 8), 600);
    chk_int("pin_len0_busy", busy_of(64'h0, 0), 88);
`endif

    repeat (2) @(negedge tb_clk);
    chk_int("reset_state", int'({d_plus, d_minus, tx_busy, tx_done}), 8);
    chk_en = 1'b1;
    n_rst  = 1'b1;
    @(negedge tb_clk);

    run_packet("a5", 64'hA5, 1, busy_of(64'hA5, 1), 1'b0);
    run_packet("ff", 64'hFF, 1, busy_of(64'hFF, 1), 1'b0);
    run_packet("w88", 64'h8888_8888_8888_8888, 8, busy_of(64'h8888_8888_8888_8888, 8), 1'b1);
    run_packet("len0", 64'h0, 0, busy_of(64'h0, 0), 1'b0);
    run_packet("clamp", 64'hFFFF_0000_A5A5_FF01, 13, busy_of(64'hFFFF_0000_A5A5_FF01, 8), 1'b0);
`ifdef USB_TX_CRC16_EN
    run_packet("crc_0100", 64'h0100, 2, busy_of(64'h0100, 2), 1'b0);
`endif

    // Reset during DATA bit 3 of a one-byte packet.
    tx_data = 64'hA5; tx_len = LW'(1); tx_start = 1'b1;
    @(negedge tb_clk);
    tx_start = 1'b0;
    repeat (88) @(negedge tb_clk);
    n_rst = 1'b0;
    @(negedge tb_clk);
    chk_int("abort_lines_busy_done", int'({d_plus, d_minus, tx_busy, tx_done}), 8);
    n_rst = 1'b1;
    bad = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge tb_clk);
      if (tx_done || (!d_plus && !d_minus) || tx_busy) bad++;
    end
    chk_int("abort_no_eop_no_done", bad, 0);

    // Random packets, some started on the tx_done cycle, with stray mid-packet starts.
    for (int p = 0; p < 30; p++) begin
      for (int b = 0; b < 8; b++) begin
        case ($urandom_range(0, 3))
          0:       d[b*8 +: 8] = 8'hFF;
          1:       d[b*8 +: 8] = 8'h00;
          default: d[b*8 +: 8] = 8'($urandom);
        endcase
      end
      len = $urandom_range(0, 12);
      tx_data = d; tx_len = LW'(len); tx_start = 1'b1;
      @(negedge tb_clk);
      n = 0;
      while (!tx_done && n < 3000) begin
        tx_start = ($urandom_range(0, 15) == 0);
        @(negedge tb_clk);
        n++;
      end
      tx_start = 1'b0;
      chk_int("rand_done_within_bound", (n < 3000) ? 1 : 0, 1);
      if ($urandom_range(0, 1) == 0) repeat ($urandom_range(1, 4)) @(negedge tb_clk);
    end

    repeat (1500) @(negedge tb_clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
